// File: rtl/keycode_uart_reporter.sv
// Purpose: report each new low-16-bit PS/2 keycode as "XXXX\r\n" over an 8N1 UART.
// Latency: start bit of the first char begins 6 clocks after the keycode settles.
// Backpressure: none upstream; one code in flight, one pending, extras dropped with overrun.
module keycode_uart_reporter #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] keycode,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Synchroniser, change detection and the single pending slot
  logic [15:0]   r_sync1, r_sync2, r_sync3;
  logic [15:0]   r_last_code;
  logic [15:0]   r_pend_code;
  logic          r_pend_vld;
  logic          r_overrun;

  // Transmit side
  state_t        r_state;
  logic [15:0]   r_frame_code;
  logic [2:0]    r_char_idx;
  logic [2:0]    r_bit_idx;
  logic [CW-1:0] r_baud_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  logic          w_stable;
  logic          w_event;
  logic          w_consume;
  logic          w_baud_done;
  logic [3:0]    w_nib;
  logic [7:0]    w_char;
  logic          w_unused_hi;

  // The upper half of the keycode word carries nothing we report.
  assign w_unused_hi = ^keycode[31:16];

  assign w_stable    = (r_sync2 == r_sync3);
  assign w_event     = w_stable && (r_sync3 != r_last_code);
  // IDLE takes the pending code this cycle, so a same-cycle event is not an overrun.
  assign w_consume   = (r_state == S_IDLE) && r_pend_vld;
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign overrun = r_overrun;

  // Bring the PS/2-domain keycode into clk through a 3-stage chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 16'h0000;
      r_sync2 <= 16'h0000;
      r_sync3 <= 16'h0000;
    end else begin
      r_sync1 <= keycode[15:0];
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Latch new stable codes into the pending slot; newest value wins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_code <= 16'h0000;
      r_pend_code <= 16'h0000;
      r_pend_vld  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_event && r_pend_vld && !w_consume;
      if (w_event) begin
        r_last_code <= r_sync3;
        r_pend_code <= r_sync3;
        r_pend_vld  <= 1'b1;
      end else if (w_consume) begin
        r_pend_vld  <= 1'b0;
      end
    end
  end

  // Pick the ASCII character for the current position in the report
  always_comb begin
    w_nib  = 4'h0;
    w_char = 8'h0A;
    case (r_char_idx)
      3'd0:    w_nib = r_frame_code[15:12];
      3'd1:    w_nib = r_frame_code[11:8];
      3'd2:    w_nib = r_frame_code[7:4];
      3'd3:    w_nib = r_frame_code[3:0];
      default: w_nib = 4'h0;
    endcase
    if (r_char_idx < 3'd4) begin
      w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
    end else if (r_char_idx == 3'd4) begin
      w_char = 8'h0D;
    end else begin
      w_char = 8'h0A;
    end
  end

  // Report FSM with registered tx/busy: 6 chars of start + 8 data + stop bits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_frame_code <= 16'h0000;
      r_char_idx   <= 3'd0;
      r_bit_idx    <= 3'd0;
      r_baud_cnt   <= '0;
      r_shift      <= 8'h00;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_baud_cnt <= '0;
          if (r_pend_vld) begin
            r_frame_code <= r_pend_code;
            r_char_idx   <= 3'd0;
            r_busy       <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The single idle-high clock between characters
          r_shift    <= w_char;
          r_tx       <= 1'b0;
          r_baud_cnt <= '0;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_shift    <= {1'b0, r_shift[7:1]};
            r_bit_idx  <= 3'd0;
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_char_idx < 3'd5) begin
              r_char_idx <= r_char_idx + 3'd1;
              r_state    <= S_LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_uart_reporter.sv
// Directed bench for keycode_uart_reporter: expected chars queued at stimulus time,
// a UART monitor decodes tx and pops/compares each character independently.
module tb_keycode_uart_reporter;

  logic        clk;
  logic        rstn;
  logic [31:0] keycode;
  logic        tx;
  logic        busy;
  logic        overrun;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  chars_seen = 0;
  int  busy_rises = 0;
  int  ovr_cnt    = 0;
  byte exp_q[$];

  keycode_uart_reporter #(
    .CLK_FREQ_HZ(1000),
    .BAUD       (100)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .keycode(keycode),
    .tx     (tx),
    .busy   (busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic set_key(input logic [31:0] v);
    @(posedge clk);
    #1 keycode = v;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0) break;
    end
    chk(name, {31'd0, (exp_q.size() == 0 && busy === 1'b0)}, 32'd1);
  endtask

  // Decode one UART character, starting on the first start-bit sample
  task automatic decode_char();
    logic [9:0] bits;
    bit uniform;
    bit aborted;
    byte e;
    bits    = '0;
    uniform = 1'b1;
    aborted = 1'b0;
    for (int slot = 0; slot < 10; slot++) begin
      for (int s = 0; s < 10; s++) begin
        if (!aborted) begin
          if (!(slot == 0 && s == 0)) @(negedge clk);
          if (!rstn) aborted = 1'b1;
          else if (s == 0) bits[slot] = tx;
          else if (tx !== bits[slot]) uniform = 1'b0;
        end
      end
    end
    if (aborted) return;
    chars_seen++;
    chk("bit_timing", {31'd0, uniform}, 32'd1);
    chk("framing", {30'd0, bits[9], bits[0]}, 32'd2);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_char: got %02h, none expected", bits[8:1]);
    end else begin
      e = exp_q.pop_front();
      chk("char", {24'd0, bits[8:1]}, {24'd0, e});
    end
  endtask

  // UART monitor
  initial begin
    logic prev_tx;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn && prev_tx && tx === 1'b0) decode_char();
      prev_tx = rstn ? tx : 1'b1;
    end
  end

  // Event counters for busy rises and overrun pulses
  initial begin
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (overrun === 1'b1) ovr_cnt++;
      if (busy === 1'b1 && !prev_busy) busy_rises++;
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    int lat;
    int cnt;
    int b0;
    int o0;
    rstn    = 1'b1;
    keycode = 32'h0;
    #2 rstn = 1'b0;

    // 1: reset state, then long quiet period with keycode 0
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2000) @(negedge clk);
    chk("t1_no_chars", chars_seen, 0);
    chk("t1_no_busy", busy_rises, 0);
    chk("t1_tx_idle", {31'd0, tx}, 32'd1);

    // 2: single code, latency and frame length
    push_str("001C\r\n");
    set_key(32'h0000_001C);
    lat = 0;
    while (tx === 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("t2_latency_le6", {31'd0, (tx === 1'b0 && lat <= 6)}, 32'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("t2_start_to_busy_fall", cnt, 605);
    wait_idle("t2_idle", 2000);

    // 3: same value again, then two new codes
    b0 = busy_rises;
    set_key(32'h0000_001C);
    repeat (100) @(negedge clk);
    chk("t3_same_no_frame", busy_rises - b0, 0);
    push_str("1CF0\r\n");
    set_key(32'h0000_1CF0);
    wait_idle("t3_idle_a", 1500);
    push_str("F01C\r\n");
    set_key(32'h001C_F01C);
    wait_idle("t3_idle_b", 1500);

    // 4: codes arriving mid-frame; middle one is overwritten
    o0 = ovr_cnt;
    push_str("0029\r\n");
    set_key(32'h0000_0029);
    repeat (150) @(posedge clk);
    set_key(32'h0000_0012);
    repeat (20) @(posedge clk);
    push_str("005A\r\n");
    set_key(32'h0000_005A);
    wait_idle("t4_idle", 3000);
    chk("t4_one_overrun", ovr_cnt - o0, 1);

    // 5: rewrites of the same low half
    b0 = busy_rises;
    o0 = ovr_cnt;
    set_key(32'h0000_005A);
    repeat (50) @(posedge clk);
    set_key(32'hABCD_005A);
    repeat (300) @(negedge clk);
    chk("t5_no_frame", busy_rises - b0, 0);
    chk("t5_no_overrun", ovr_cnt - o0, 0);

    // 6: reset during data bit 0 of the 2nd char, then a clean report
    o0 = ovr_cnt;
    push_str("0");
    set_key(32'h0000_0066);
    lat = 0;
    while (tx === 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("t6_frame_started", {31'd0, tx}, 32'd0);
    repeat (115) @(posedge clk);
    #1;
    chk("t6_tx_low_before_rst", {31'd0, tx}, 32'd0);
    #1;
    rstn    = 1'b0;
    keycode = 32'h0;
    #1;
    chk("t6_rst_tx_high", {31'd0, tx}, 32'd1);
    chk("t6_rst_busy_low", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_partial_frame_dropped", exp_q.size(), 0);
    chk("t6_idle_after_rst", {30'd0, tx, busy}, 32'd2);
    push_str("0033\r\n");
    set_key(32'h0000_0033);
    wait_idle("t6_idle", 1500);
    chk("t6_no_overrun", ovr_cnt - o0, 0);
    chk("all_consumed", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
